program_counter_stack: RTL and testbench
========================================

Name: program_counter_stack

Overview:
- Parametrised program counter for the single-cycle datapath. It generalises the existing 6-bit PS-controlled PC in three ways: configurable address width, an enable/stall input, and a hardware return-address stack for call/return.
- It sits between the instruction decoder, which drives PS, SA, SB and A, and instruction memory, which consumes PC.
- Stack-overflow and stack-underflow faults are reported as sticky flags to the control unit.

Parameters:
- PC_W, 6, width of PC, A and the stack entries.
- SEL_W, 4, width of each of SA and SB. The branch offset is {SA,SB}, which is 2*SEL_W bits.
- STACK_DEPTH, 4, number of return-address entries. Must be ≥2 and a power of 2.
- RESET_VEC, 0, value loaded into PC on reset.

Ports:
- clk_main  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; overrides every other input.
- en  in  1  1 = execute PS this cycle; 0 = stall, all state holds.
- PS  in  3  PC operation select (encoding under Behaviour).
- A  in  PC_W  absolute target for jump and call.
- SA  in  SEL_W  upper half of the relative branch offset.
- SB  in  SEL_W  lower half of the relative branch offset.
- PC  out  PC_W  current program counter (registered).
- sp  out  clog2(STACK_DEPTH)+1  number of valid stack entries.
- stack_full  out  1  sp == STACK_DEPTH (combinational from sp).
- stack_empty  out  1  sp == 0 (combinational from sp).
- ovf_err  out  1  sticky: a call was attempted while the stack was full.
- udf_err  out  1  sticky: a return was attempted while the stack was empty.

Behaviour:
- Reset (sync, on the clk_main edge with reset=1):
  - PC <= RESET_VEC, sp <= 0, ovf_err <= 0, udf_err <= 0.
  - Stack contents are don't-care.
  - Reset wins over en and PS, including mid-call or mid-return.
- en=0: PC, sp, stack contents and error flags all hold, whatever PS is.
- PS encoding, applied on the edge when en=1 and reset=0. All arithmetic is modulo 2^PC_W.
  - 000 HOLD: PC <= PC.
  - 001 INC: PC <= PC + 1. 2^PC_W-1 wraps to 0.
  - 010 BRANCH: PC <= PC + off.
    - off = {SA,SB} as two's complement, sign-extended to PC_W.
    - If 2*SEL_W > PC_W, off is truncated to its low PC_W bits.
  - 011 JUMP: PC <= A.
  - 100 CALL:
    - If !stack_full: stack[sp] <= PC + 1 (wrapped), sp <= sp + 1, PC <= A.
    - If stack_full: PC, sp and stack all hold; ovf_err <= 1.
  - 101 RETURN:
    - If !stack_empty: PC <= stack[sp-1], sp <= sp - 1.
    - If stack_empty: PC and sp hold; udf_err <= 1.
  - 110, 111 reserved: behave as HOLD. No error is flagged.
- Latency:
  - PC reflects an operation one cycle after the edge that samples it.
  - sp, stack_full and stack_empty update on the same edge as PC.
- The stack is a LIFO register array. Only one push or pop happens per cycle.
- Error flags are cleared only by reset. While a flag is set, further operations still execute normally.
- The existing PS=00/01/10/11 semantics are preserved in the 3-bit encoding, using codes 000/001/010/011.

Test Plan:
- Reset then INC: reset=1 for one edge gives PC=0 and sp=0. Then PS=001 for 3 edges gives PC=1,2,3. Driving 63 with PS=001 (PC_W=6) wraps PC to 0.
- BRANCH sign handling: PC=10 with SA=4'hF, SB=4'hD (off=-3) and PS=010 gives PC=7. PC=60 with SA=0, SB=8 gives PC=4 (wrap).
- CALL/RETURN nest:
  - PC=5, A=20, PS=100 gives PC=20, sp=1.
  - PS=100 with A=40 gives PC=40, sp=2.
  - PS=101 gives PC=21, sp=1.
  - PS=101 gives PC=6, sp=0, stack_empty=1.
- Overflow: 4 calls (PC=0 each step with A=8,9,10,11) give sp=4 and stack_full=1. A 5th call with A=50 leaves PC=11 and sp=4, and sets ovf_err=1. Then 4 returns give PC=11,10,9,1.
- Underflow and stall:
  - A return at sp=0 leaves PC held and sets udf_err=1.
  - With en=0 and PS=011, A=33 for 2 edges, PC and sp hold.
  - With en=1 and the same PS=011, A=33, PC=33.
- Reset priority: reset=1 with en=1, PS=100, A=12 and sp=2 gives PC=0, sp=0, and ovf_err and udf_err both 0.

Source files
------------

// File: rtl/program_counter_stack.sv
// -----------------------------------------------------------------------------
// program_counter_stack
//
// Program counter for the single-cycle datapath. The decoder selects the next
// PC through PS. The options are hold, increment, relative branch, absolute
// jump, call and return. Call pushes the return address onto a small LIFO.
// Return pops the return address from that LIFO. Stack overflow and underflow
// attempts raise sticky flags for the control unit. A stall input (en=0)
// freezes all state.
//
// Ports:
//   clk_main     in   system clock, all state updates on the rising edge
//   reset        in   synchronous active-high reset, beats every other input
//   en           in   1 = execute PS this cycle, 0 = stall
//   PS           in   [2:0] PC operation select
//   A            in   [PC_W-1:0] absolute target for jump / call
//   SA, SB       in   [SEL_W-1:0] upper / lower halves of the branch offset
//   PC           out  [PC_W-1:0] current program counter (registered)
//   sp           out  number of valid return-address entries
//   stack_full   out  sp == STACK_DEPTH
//   stack_empty  out  sp == 0
//   ovf_err      out  sticky: call attempted while the stack was full
//   udf_err      out  sticky: return attempted while the stack was empty
// -----------------------------------------------------------------------------
module program_counter_stack #(
  parameter int              PC_W        = 6,
  parameter int              SEL_W       = 4,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_VEC   = '0
) (
  input  logic                         clk_main,
  input  logic                         reset,
  input  logic                         en,
  input  logic [2:0]                   PS,
  input  logic [PC_W-1:0]              A,
  input  logic [SEL_W-1:0]             SA,
  input  logic [SEL_W-1:0]             SB,
  output logic [PC_W-1:0]              PC,
  output logic [$clog2(STACK_DEPTH):0] sp,
  output logic                         stack_full,
  output logic                         stack_empty,
  output logic                         ovf_err,
  output logic                         udf_err
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = PTR_W + 1;
  localparam int OFF_W = 2 * SEL_W;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'b000,
    OP_INC    = 3'b001,
    OP_BRANCH = 3'b010,
    OP_JUMP   = 3'b011,
    OP_CALL   = 3'b100,
    OP_RETURN = 3'b101
  } pc_op_e;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [PC_W-1:0]  stack_q [STACK_DEPTH];

  logic [PC_W-1:0]  pc_plus1;
  logic [PC_W-1:0]  off_ext;
  logic [OFF_W-1:0] off_raw;
  logic [PTR_W-1:0] push_idx;
  logic [PTR_W-1:0] pop_idx;
  logic             push;
  pc_op_e           op;

  assign op       = pc_op_e'(PS);
  assign pc_plus1 = pc_q + PC_W'(1);
  assign off_raw  = {SA, SB};
  // Entries occupy stack_q[0 .. sp-1]. The next push lands at sp.
  // The top entry is at sp-1.
  assign push_idx = sp_q[PTR_W-1:0];
  assign pop_idx  = sp_q[PTR_W-1:0] - PTR_W'(1);

  // Fit the two's-complement branch offset to PC_W bits. A wide offset is
  // truncated, which is equivalent modulo 2^PC_W. A narrow offset is
  // sign-extended.
  generate
    if (OFF_W > PC_W) begin : g_off_trunc
      logic unused_off_hi;
      assign unused_off_hi = ^off_raw[OFF_W-1:PC_W];
      assign off_ext       = off_raw[PC_W-1:0];
    end else if (OFF_W == PC_W) begin : g_off_same
      assign off_ext = off_raw;
    end else begin : g_off_sext
      assign off_ext = {{(PC_W-OFF_W){off_raw[OFF_W-1]}}, off_raw};
    end
  endgenerate

  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    push  = 1'b0;
    if (en) begin
      case (op)
        OP_INC:    pc_d = pc_plus1;
        OP_BRANCH: pc_d = pc_q + off_ext;
        OP_JUMP:   pc_d = A;
        OP_CALL: begin
          if (!stack_full) begin
            push = 1'b1;
            sp_d = sp_q + SP_W'(1);
            pc_d = A;
          end else begin
            ovf_d = 1'b1;
          end
        end
        OP_RETURN: begin
          if (!stack_empty) begin
            pc_d = stack_q[pop_idx];
            sp_d = sp_q - SP_W'(1);
          end else begin
            udf_d = 1'b1;
          end
        end
        default: ; // HOLD and the reserved codes leave everything unchanged
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge.
  always_ff @(posedge clk_main) begin
    if (reset) begin
      pc_q  <= RESET_VEC;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // NOTE: the stack array has no reset. sp=0 already marks every entry
  // invalid, so clearing the storage would only cost logic.
  always_ff @(posedge clk_main) begin
    if (!reset && push) begin
      stack_q[push_idx] <= pc_plus1;
    end
  end

  assign PC      = pc_q;
  assign sp      = sp_q;
  assign ovf_err = ovf_q;
  assign udf_err = udf_q;

endmodule

// File: tb/tb_program_counter_stack.sv
// -----------------------------------------------------------------------------
// tb_program_counter_stack
//
// Directed vector table for the call/return, wrap, overflow, underflow, stall
// and reset-priority cases. After that, a randomized phase compares the DUT
// against a queue-based reference model of the PC and return stack.
// -----------------------------------------------------------------------------
module tb_program_counter_stack;

  localparam int PC_W  = 6;
  localparam int SEL_W = 4;
  localparam int DEPTH = 4;
  localparam int MOD   = 1 << PC_W;

  localparam logic [2:0] HOLD = 3'b000, INC = 3'b001, BRANCH = 3'b010,
                         JUMP = 3'b011, CALL = 3'b100, RET = 3'b101;

  logic              clk_main = 1'b0;
  logic              reset;
  logic              en;
  logic [2:0]        PS;
  logic [PC_W-1:0]   A;
  logic [SEL_W-1:0]  SA, SB;
  logic [PC_W-1:0]   PC;
  logic [2:0]        sp;
  logic              stack_full, stack_empty, ovf_err, udf_err;

  int n_checks = 0;
  int n_fail   = 0;

  program_counter_stack #(
    .PC_W(PC_W), .SEL_W(SEL_W), .STACK_DEPTH(DEPTH), .RESET_VEC('0)
  ) dut (
    .clk_main   (clk_main),
    .reset      (reset),
    .en         (en),
    .PS         (PS),
    .A          (A),
    .SA         (SA),
    .SB         (SB),
    .PC         (PC),
    .sp         (sp),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .ovf_err    (ovf_err),
    .udf_err    (udf_err)
  );

  always #5 clk_main = ~clk_main;

  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic [2:0] ps;
    int         a;
    int         sa;
    int         sb;
    int         exp_pc;
    int         exp_sp;
    logic       exp_ovf;
    logic       exp_udf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic add(input string name, input logic rst, input logic en_v,
                     input logic [2:0] ps, input int a, input int sa, input int sb,
                     input int pc, input int spv, input logic ovf, input logic udf);
    vec_t v;
    v.name = name; v.rst = rst; v.en = en_v; v.ps = ps; v.a = a; v.sa = sa; v.sb = sb;
    v.exp_pc = pc; v.exp_sp = spv; v.exp_ovf = ovf; v.exp_udf = udf;
    vecs.push_back(v);
  endtask

  // Drive inputs, take one rising edge, and let outputs settle before sampling.
  task automatic step(input logic rst, input logic en_v, input logic [2:0] ps,
                      input int a, input int sa, input int sb);
    reset = rst; en = en_v; PS = ps;
    A  = PC_W'(a);
    SA = SEL_W'(sa);
    SB = SEL_W'(sb);
    @(posedge clk_main);
    #1;
  endtask

  task automatic check_all(input string name, input int pc, input int spv,
                           input logic ovf, input logic udf);
    check({name, ".pc"},    int'(PC),          pc);
    check({name, ".sp"},    int'(sp),          spv);
    check({name, ".full"},  int'(stack_full),  int'(spv == DEPTH));
    check({name, ".empty"}, int'(stack_empty), int'(spv == 0));
    check({name, ".ovf"},   int'(ovf_err),     int'(ovf));
    check({name, ".udf"},   int'(udf_err),     int'(udf));
  endtask

  // Reference model of the PC and return stack.
  int m_pc;
  int m_stack[$];
  bit m_ovf, m_udf;

  task automatic model_step(input logic rst, input logic en_v, input logic [2:0] ps,
                            input int a, input int sa, input int sb);
    int off;
    if (rst) begin
      m_pc = 0; m_stack.delete(); m_ovf = 0; m_udf = 0;
      return;
    end
    if (!en_v) return;
    case (ps)
      INC:    m_pc = (m_pc + 1) % MOD;
      BRANCH: begin
        off = sa * (1 << SEL_W) + sb;
        if (off >= (1 << (2*SEL_W-1))) off -= (1 << (2*SEL_W));
        m_pc = (((m_pc + off) % MOD) + MOD) % MOD;
      end
      JUMP:   m_pc = a;
      CALL: begin
        if (m_stack.size() < DEPTH) begin
          m_stack.push_back((m_pc + 1) % MOD);
          m_pc = a;
        end else m_ovf = 1;
      end
      RET: begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else m_udf = 1;
      end
      default: ;
    endcase
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; PS = HOLD; A = '0; SA = '0; SB = '0;

    // name, rst, en, ps, A, SA, SB, exp PC, exp sp, exp ovf, exp udf
    add("reset",      1, 1, HOLD,    0,  0,  0,  0, 0, 0, 0);
    add("inc1",       0, 1, INC,     0,  0,  0,  1, 0, 0, 0);
    add("inc2",       0, 1, INC,     0,  0,  0,  2, 0, 0, 0);
    add("inc3",       0, 1, INC,     0,  0,  0,  3, 0, 0, 0);
    add("jmp63",      0, 1, JUMP,   63,  0,  0, 63, 0, 0, 0);
    add("inc_wrap",   0, 1, INC,     0,  0,  0,  0, 0, 0, 0);
    add("jmp10",      0, 1, JUMP,   10,  0,  0, 10, 0, 0, 0);
    add("br_neg3",    0, 1, BRANCH,  0, 15, 13,  7, 0, 0, 0);
    add("jmp60",      0, 1, JUMP,   60,  0,  0, 60, 0, 0, 0);
    add("br_wrap",    0, 1, BRANCH,  0,  0,  8,  4, 0, 0, 0);
    add("jmp5",       0, 1, JUMP,    5,  0,  0,  5, 0, 0, 0);
    add("call20",     0, 1, CALL,   20,  0,  0, 20, 1, 0, 0);
    add("call40",     0, 1, CALL,   40,  0,  0, 40, 2, 0, 0);
    add("ret21",      0, 1, RET,     0,  0,  0, 21, 1, 0, 0);
    add("ret6",       0, 1, RET,     0,  0,  0,  6, 0, 0, 0);
    add("jmp0",       0, 1, JUMP,    0,  0,  0,  0, 0, 0, 0);
    add("call8",      0, 1, CALL,    8,  0,  0,  8, 1, 0, 0);
    add("call9",      0, 1, CALL,    9,  0,  0,  9, 2, 0, 0);
    add("call10",     0, 1, CALL,   10,  0,  0, 10, 3, 0, 0);
    add("call11",     0, 1, CALL,   11,  0,  0, 11, 4, 0, 0);
    add("call_ovf",   0, 1, CALL,   50,  0,  0, 11, 4, 1, 0);
    add("ret_a",      0, 1, RET,     0,  0,  0, 11, 3, 1, 0);
    add("ret_b",      0, 1, RET,     0,  0,  0, 10, 2, 1, 0);
    add("ret_c",      0, 1, RET,     0,  0,  0,  9, 1, 1, 0);
    add("ret_d",      0, 1, RET,     0,  0,  0,  1, 0, 1, 0);
    add("ret_udf",    0, 1, RET,     0,  0,  0,  1, 0, 1, 1);
    add("stall1",     0, 0, JUMP,   33,  0,  0,  1, 0, 1, 1);
    add("stall2",     0, 0, JUMP,   33,  0,  0,  1, 0, 1, 1);
    add("jmp33",      0, 1, JUMP,   33,  0,  0, 33, 0, 1, 1);
    add("call7",      0, 1, CALL,    7,  0,  0,  7, 1, 1, 1);
    add("call8b",     0, 1, CALL,    8,  0,  0,  8, 2, 1, 1);
    add("stall_call", 0, 0, CALL,   20,  0,  0,  8, 2, 1, 1);
    add("rst_prio",   1, 1, CALL,   12,  0,  0,  0, 0, 0, 0);
    add("inc_after",  0, 1, INC,     0,  0,  0,  1, 0, 0, 0);
    add("rsv110",     0, 1, 3'b110,  9,  3,  3,  1, 0, 0, 0);
    add("rsv111",     0, 1, 3'b111,  9,  3,  3,  1, 0, 0, 0);
    add("ret_empty2", 0, 1, RET,     0,  0,  0,  1, 0, 0, 1);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].ps, vecs[i].a, vecs[i].sa, vecs[i].sb);
      check_all(vecs[i].name, vecs[i].exp_pc, vecs[i].exp_sp,
                vecs[i].exp_ovf, vecs[i].exp_udf);
    end

    // Sequence: a stalled return must not pop. The following real return
    // must still reach the entry that was pushed first.
    step(1, 0, HOLD, 0, 0, 0);
    step(0, 1, CALL, 30, 0, 0);           // pushes 1, PC=30
    step(0, 0, RET, 0, 0, 0);
    check_all("seq_stall_ret", 30, 1, 0, 0);
    step(0, 1, RET, 0, 0, 0);
    check_all("seq_ret", 1, 0, 0, 0);

    // Randomized phase checked against the reference model.
    step(1, 1, HOLD, 0, 0, 0);
    model_step(1, 1, HOLD, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      logic       r_rst, r_en;
      logic [2:0] r_ps;
      int         r_a, r_sa, r_sb, pick;
      r_rst = ($urandom_range(0, 59) == 0);
      r_en  = ($urandom_range(0, 9) != 0);
      pick  = $urandom_range(0, 11);
      r_ps  = (pick < 3) ? CALL : (pick < 6) ? RET : 3'($urandom_range(0, 7));
      r_a   = $urandom_range(0, MOD - 1);
      r_sa  = $urandom_range(0, (1 << SEL_W) - 1);
      r_sb  = $urandom_range(0, (1 << SEL_W) - 1);
      step(r_rst, r_en, r_ps, r_a, r_sa, r_sb);
      model_step(r_rst, r_en, r_ps, r_a, r_sa, r_sb);
      check_all($sformatf("rand%0d", i), m_pc, m_stack.size(), m_ovf, m_udf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
